mult_seq_core: RTL and testbench

- Sequential datapath and control for the 8×8 signed (two's-complement) shift-add multiplier.
- Holds the X/A/B registers, bit counter and FSM, and drives the external 9-bit add/subtract stage.
- Consumes that stage's sum and produces a 16-bit product in A:B, with X as the sign extension.
- Sits between the switch/button input logic and the hex display drivers.

---
 rtl/mult_seq_core.sv | 144 ++++++++++++++
 tb/tb_mult_seq_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_core.sv
// mult_seq_core
// Control and register datapath of the 8x8 signed shift-add multiplier.
// The X/A/B registers, the 3-bit bit counter and the IDLE/ADD/SHIFT/DONE
// controller live here. The 9-bit add/subtract stage sits outside the block:
// this block drives its operands (AddA, AddB) and its function (Fn), and
// takes its result back on Sum.
//
// When the product is complete, {A,B} holds the 16-bit signed product and
// X holds its sign extension.
//
// Build option:
//   MULT_SKIP_ADD_EN
//     When this macro is defined, the controller skips the ADD state for
//     every multiplier bit that is 0. The multiply then takes
//     8 + popcount(B) cycles instead of a fixed 16. The result is the same
//     in both builds.
module mult_seq_core (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] Sw,
  input  logic [8:0] Sum,
  output logic [7:0] AddA,
  output logic [7:0] AddB,
  output logic       Fn,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval,
  output logic       Done
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state;
  logic [2:0]                cnt;
  logic                      x_r;
  logic signed [DATA_W-1:0]  a_r;
  logic signed [DATA_W-1:0]  b_r;
  logic                      done_r;

  // Controller and X/A/B registers. The whole datapath is cleared by the
  // asynchronous reset, so a multiply that is aborted part-way leaves no
  // stale partial product behind.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      x_r    <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Loading B takes precedence over starting a multiply.
          if (ClearA_LoadB) begin
            x_r <= 1'b0;
            a_r <= '0;
            b_r <= Sw;
          end else if (Run) begin
            x_r <= 1'b0;
            a_r <= '0;
            cnt <= 3'd0;
`ifdef MULT_SKIP_ADD_EN
            // Skip the ADD state when the first multiplier bit is 0.
            state <= b_r[0] ? ADD : SHIFT;
`else
            state <= ADD;
`endif
          end
        end

        ADD: begin
          // Accumulate a partial product only when the current multiplier
          // bit is 1. On the last bit (cnt==7) the external adder
          // subtracts, which gives the negative weight of the sign bit.
          if (b_r[0]) begin
            x_r <= Sum[8];
            a_r <= Sum[7:0];
          end
          state <= SHIFT;
        end

        SHIFT: begin
          // Arithmetic right shift of {X,A,B}. X is the sign bit and
          // therefore holds its value.
          a_r <= {x_r, a_r[DATA_W-1:1]};
          b_r <= {a_r[0], b_r[DATA_W-1:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
`ifdef MULT_SKIP_ADD_EN
            // b_r[1] is the bit that will sit in B[0] after this shift.
            state <= b_r[1] ? ADD : SHIFT;
`else
            state <= ADD;
`endif
          end
        end

        DONE: begin
          // Leave DONE only after Run falls. Run must then rise again to
          // start the next multiply.
          if (!Run) begin
            state  <= IDLE;
            done_r <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Adder interface. The subtract function covers the sign-bit partial
  // product, and the bit counter reaches 7 only while that bit is handled.
  always_comb begin
    AddA = a_r;
    AddB = Sw;
    Fn   = (cnt == 3'd7);
  end

  // Register taps for the display drivers.
  always_comb begin
    Aval = a_r;
    Bval = b_r;
    Xval = x_r;
    Done = done_r;
  end

endmodule

// File: tb/tb_mult_seq_core.sv
// tb_mult_seq_core
// Scoreboard bench for mult_seq_core. A combinational model of the external
// 9-bit add/subtract stage closes the loop. Each multiply that is started
// pushes its expected result and expected completion cycle into a queue.
// A monitor compares against that queue whenever Done rises.
module tb_mult_seq_core;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic [7:0] Sw = 8'h00;
  logic [8:0] Sum;
  logic [7:0] AddA, AddB, Aval, Bval;
  logic       Fn, Xval, Done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    int         done_cyc;
    int         fn_cycles;
  } exp_t;

  exp_t sb[$];

  mult_seq_core dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Sw(Sw), .Sum(Sum), .AddA(AddA), .AddB(AddB), .Fn(Fn),
    .Aval(Aval), .Bval(Bval), .Xval(Xval), .Done(Done)
  );

  // External adder: 9-bit sign-extended add or subtract.
  assign Sum = Fn ? ({AddA[7], AddA} - {AddB[7], AddB})
                  : ({AddA[7], AddA} + {AddB[7], AddB});

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] b);
`ifdef MULT_SKIP_ADD_EN
    return 8 + $countones(b);
`else
    return 16;
`endif
  endfunction

  function automatic int exp_fn_cycles(input logic [7:0] b);
`ifdef MULT_SKIP_ADD_EN
    return 1 + int'(b[7]);
`else
    return 2;
`endif
  endfunction

  // Monitor: when Done rises, pop the oldest expectation and compare.
  logic done_q = 1'b0;
  int   fn_cnt = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      done_q = 1'b0;
      fn_cnt = 0;
    end else begin
      if (Fn) fn_cnt++;
      if (Done && !done_q) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got Done=1 expected no pending multiply");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_A"},   32'(Aval), 32'(e.a));
          chk({e.name, "_B"},   32'(Bval), 32'(e.b));
          chk({e.name, "_X"},   32'(Xval), 32'(e.x));
          chk({e.name, "_lat"}, 32'(cyc),  32'(e.done_cyc));
          chk({e.name, "_fn"},  32'(fn_cnt), 32'(e.fn_cycles));
        end
        fn_cnt = 0;
      end
      done_q = Done;
    end
  end

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clk);
      if (Done) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no Done expected Done within 60 cycles", nm);
    end
  endtask

  // One multiply: optionally load B, then raise Run with the multiplicand.
  // binit is the value of B at the Run edge, and it sets the expected
  // timing.
  task automatic do_mult(input string nm, input bit load, input logic [7:0] b,
                         input logic [7:0] s, input logic [7:0] ea,
                         input logic [7:0] eb, input logic ex, input int hold);
    exp_t e;
    logic [7:0] binit;
    binit = load ? b : Bval;
    if (load) begin
      @(negedge Clk);
      Sw = b;
      ClearA_LoadB = 1'b1;
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
    end
    @(negedge Clk);
    Sw  = s;
    Run = 1'b1;
    e.name      = nm;
    e.a         = ea;
    e.b         = eb;
    e.x         = ex;
    e.done_cyc  = cyc + 1 + exp_latency(binit);
    e.fn_cycles = exp_fn_cycles(binit);
    sb.push_back(e);
    wait_done(nm);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk({nm, "_hold_done"}, 32'(Done), 32'd1);
      chk({nm, "_hold_B"},    32'(Bval), 32'(eb));
    end
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    chk({nm, "_done_fall"}, 32'(Done), 32'd0);
  endtask

  initial begin
    logic [7:0]  rb, rs;
    logic [15:0] p;
    bit          saw;

    // Check the outputs while reset is asserted.
    repeat (3) @(negedge Clk);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_fn",   32'(Fn),   32'd0);
    chk("rst_A",    32'(Aval), 32'd0);
    chk("rst_B",    32'(Bval), 32'd0);
    chk("rst_X",    32'(Xval), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Directed vectors with hand-computed products.
    do_mult("m7x59",   1, 8'h07, 8'h3B, 8'h01, 8'h9D, 1'b0, 0);  // 413
    chk("addb_follows_sw", 32'(AddB), 32'h3B);
    do_mult("mn3x2",   1, 8'hFD, 8'h02, 8'hFF, 8'hFA, 1'b1, 0);  // -6
    do_mult("mn128sq", 1, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 0);  // 16384
    do_mult("mn1sq",   1, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 5);  // 1, Run held
    do_mult("reuseB",  0, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0, 0);  // B=1 reused
    do_mult("zero",    1, 8'h00, 8'h85, 8'h00, 8'h00, 1'b0, 0);  // 0, X=0
    do_mult("max_pos", 1, 8'h7F, 8'h7F, 8'h3F, 8'h01, 1'b0, 0);  // 16129
    do_mult("mixed",   1, 8'h80, 8'h7F, 8'hC0, 8'h80, 1'b1, 0);  // -16256
    do_mult("m1x5",    1, 8'h01, 8'h05, 8'h00, 8'h05, 1'b0, 0);  // 5

    // Abort a multiply with an asynchronous reset in mid-operation.
    @(negedge Clk);
    Sw = 8'h55;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    Sw = 8'h33;
    Run = 1'b1;
    repeat (7) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_fn",   32'(Fn),   32'd0);
    chk("midrst_A",    32'(Aval), 32'd0);
    chk("midrst_B",    32'(Bval), 32'd0);
    chk("midrst_X",    32'(Xval), 32'd0);
    Run = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;

    // Run and ClearA_LoadB together: B is loaded and no multiply starts.
    @(negedge Clk);
    Sw = 8'h5A;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    repeat (3) @(negedge Clk);
    chk("both_B", 32'(Bval), 32'h5A);
    chk("both_A", 32'(Aval), 32'h00);
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    saw = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done) saw = 1;
    end
    chk("both_no_start", 32'(saw), 32'd0);
    do_mult("after_both", 0, 8'h00, 8'h02, 8'h00, 8'hB4, 1'b0, 0);  // 90*2=180

    // Pseudo-random pairs checked against the signed product.
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = 8'($urandom_range(0, 255));
      p  = 16'($signed(rb) * $signed(rs));
      do_mult("rand", 1, rb, rs, p[15:8], p[7:0], (p != 16'd0) ? p[15] : 1'b0, 0);
    end

    repeat (2) @(negedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
